// File: rtl/sm_adder_seq.sv
//------------------------------------------------------------------------------
// Module      : sm_adder_seq
// Description : Multi-cycle sign-magnitude adder (z = a + b) with a
//               start/busy/done handshake. Optional macro SM_ADDER_SUB_EN
//               adds an op port that selects a - b.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sm_adder_seq #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SM_ADDER_SUB_EN
    input  logic             op,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   z
);

    localparam int c_MW = WIDTH - 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CMP  = 2'd1;
    localparam logic [1:0] c_EXEC = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]       r_state;
    logic             r_sa;
    logic             r_sb;
    logic [c_MW-1:0]  r_ma;
    logic [c_MW-1:0]  r_mb;
    logic             r_same;
    logic             r_ge;
    logic [WIDTH:0]   r_z;

    logic             w_sb_in;
    logic [WIDTH-1:0] w_mag;
    logic             w_sign;
    logic             w_sign_n;

`ifdef SM_ADDER_SUB_EN
    // Subtraction is addition with b's sign flipped at capture time.
    assign w_sb_in = b[WIDTH-1] ^ op;
`else
    assign w_sb_in = b[WIDTH-1];
`endif

    always_comb begin
        w_mag  = '0;
        w_sign = 1'b0;
        if (r_same) begin
            w_mag  = {1'b0, r_ma} + {1'b0, r_mb};
            w_sign = r_sa;
        end else if (r_ge) begin
            w_mag  = {1'b0, r_ma - r_mb};
            w_sign = r_sa;
        end else begin
            w_mag  = {1'b0, r_mb - r_ma};
            w_sign = r_sb;
        end
    end

    // A zero magnitude always leaves with a positive sign.
    assign w_sign_n = (w_mag == '0) ? 1'b0 : w_sign;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_ma    <= '0;
            r_mb    <= '0;
            r_same  <= 1'b0;
            r_ge    <= 1'b0;
            r_z     <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_sa    <= a[WIDTH-1];
                        r_sb    <= w_sb_in;
                        r_ma    <= a[c_MW-1:0];
                        r_mb    <= b[c_MW-1:0];
                        r_state <= c_CMP;
                    end
                end
                c_CMP: begin
                    r_same  <= (r_sa == r_sb);
                    r_ge    <= (r_ma >= r_mb);
                    r_state <= c_EXEC;
                end
                c_EXEC: begin
                    r_z     <= {w_sign_n, w_mag};
                    r_state <= c_DONE;
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == c_CMP) || (r_state == c_EXEC);
    assign done = (r_state == c_DONE);
    assign z    = r_z;

endmodule

`default_nettype wire

// File: tb/tb_sm_adder_seq.sv
//------------------------------------------------------------------------------
// Module      : tb_sm_adder_seq
// Description : Self-checking bench for sm_adder_seq (vector table plus
//               handshake and reset sequences).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sm_adder_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [17:0] a;
    logic [17:0] b;
    logic        busy;
    logic        done;
    logic [18:0] z;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [17:0] a;
        logic [17:0] b;
        logic        op;
        logic [18:0] z;
    } vec_t;

    vec_t vecs[$];

    sm_adder_seq #(.WIDTH(18)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef SM_ADDER_SUB_EN
        .op    (op),
`endif
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .z     (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Launches one operation and watches a fixed window of cycles after E0.
    task automatic run_op(input logic [17:0] ta, input logic [17:0] tb_v, input logic top,
                          output logic [18:0] zo, output int nbusy, output int ndone,
                          output int lat);
        @(negedge clk);
        a = ta; b = tb_v; op = top; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = '0; b = '0;
        nbusy = 0; ndone = 0; lat = -1; zo = '0;
        for (int i = 1; i <= 8; i++) begin
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (lat < 0) lat = i;
                zo = z;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [18:0] zr;
        int nb, nd, lt;

        vecs.push_back('{18'h00005, 18'h00003, 1'b0, 19'h00008});
        vecs.push_back('{18'h00003, 18'h20005, 1'b0, 19'h40002});
        vecs.push_back('{18'h3FFFF, 18'h3FFFF, 1'b0, 19'h7FFFE});
        vecs.push_back('{18'h00007, 18'h20007, 1'b0, 19'h00000});
        vecs.push_back('{18'h20000, 18'h20000, 1'b0, 19'h00000});
        vecs.push_back('{18'h20005, 18'h00003, 1'b0, 19'h40002});
        vecs.push_back('{18'h2000A, 18'h0000A, 1'b0, 19'h00000});
        vecs.push_back('{18'h1FFFF, 18'h00001, 1'b0, 19'h20000});
        vecs.push_back('{18'h00000, 18'h20000, 1'b0, 19'h00000});
        vecs.push_back('{18'h00004, 18'h3FFFF, 1'b0, 19'h5FFFB});
`ifdef SM_ADDER_SUB_EN
        vecs.push_back('{18'h00005, 18'h00003, 1'b1, 19'h00002});
        vecs.push_back('{18'h00003, 18'h20005, 1'b1, 19'h00008});
        vecs.push_back('{18'h00003, 18'h00005, 1'b1, 19'h40002});
`endif

        rst = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_z", {13'b0, z}, 32'd0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, zr, nb, nd, lt);
            chk($sformatf("v%0d_z", i), {13'b0, zr}, {13'b0, vecs[i].z});
            chk($sformatf("v%0d_latency", i), lt, 32'd3);
            chk($sformatf("v%0d_busy_cycles", i), nb, 32'd2);
            chk($sformatf("v%0d_done_pulses", i), nd, 32'd1);
            chk($sformatf("v%0d_z_hold", i), {13'b0, z}, {13'b0, vecs[i].z});
        end

        // start held high through CMP/EXEC with new operands must be ignored.
        @(negedge clk);
        a = 18'h00005; b = 18'h00003; op = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 18'h00100; b = 18'h00007;
        @(negedge clk);
        a = 18'h20050;
        @(negedge clk);
        start = 1'b0;
        chk("repulse_done", {31'b0, done}, 32'd1);
        chk("repulse_z", {13'b0, z}, 32'h00008);
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("repulse_extra_done", nd, 32'd0);

        // Reset asserted while in EXEC aborts the operation.
        a = 18'h00009; b = 18'h00002; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_in_exec_busy", {31'b0, busy}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_z", {13'b0, z}, 32'd0);
        rst = 1'b1;
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_no_done", nd, 32'd0);
        chk("abort_z_stays", {13'b0, z}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
